// File: rtl/inc_pulse_gen.sv
// Push-button increment pulse generator.
// Synchronizes a raw bouncing button and an auto-repeat enable, debounces the
// button, then emits single-cycle inc pulses: one per press, plus auto-repeat
// pulses after a hold delay while repeat is enabled.
module inc_pulse_gen #(
    parameter int unsigned DB_CYCLES  = 16'd1000,
    parameter int unsigned RPT_DELAY  = 16'd20000,
    parameter int unsigned RPT_PERIOD = 16'd5000,
    parameter int unsigned CW         = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    input  logic rpt_en,
    output logic inc,
    output logic pressed
);

    localparam logic [CW-1:0] DB_LAST     = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] DELAY_LAST  = CW'(RPT_DELAY - 1);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(RPT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } stateT;

    logic          r_btnMeta;
    logic          r_btnSync;
    logic          r_rptMeta;
    logic          r_rptSync;
    logic          r_dbLevel;
    logic [CW-1:0] r_dbCnt;
    stateT         r_state;
    logic [CW-1:0] r_rptCnt;
    logic          r_inc;
    logic          r_pressed;

    stateT         w_nextState;
    logic [CW-1:0] w_nextRptCnt;
    logic          w_incNext;

    // Two-flop synchronizers bring the asynchronous button and repeat enable
    // into the clock domain; nothing downstream looks at the raw inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btnMeta <= 1'b0;
            r_btnSync <= 1'b0;
            r_rptMeta <= 1'b0;
            r_rptSync <= 1'b0;
        end else begin
            r_btnMeta <= btn_in;
            r_btnSync <= r_btnMeta;
            r_rptMeta <= rpt_en;
            r_rptSync <= r_rptMeta;
        end
    end

    // Debounce: a new level is accepted only after DB_CYCLES consecutive
    // cycles of the synchronized button disagreeing with the current level;
    // any agreeing cycle restarts the count, so short glitches never land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dbLevel <= 1'b0;
            r_dbCnt   <= '0;
        end else if (r_btnSync == r_dbLevel) begin
            r_dbCnt   <= '0;
        end else if (r_dbCnt == DB_LAST) begin
            r_dbLevel <= r_btnSync;
            r_dbCnt   <= '0;
        end else begin
            r_dbCnt   <= r_dbCnt + 1'b1;
        end
    end

    // FSM state and repeat timer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_rptCnt <= '0;
        end else begin
            r_state  <= w_nextState;
            r_rptCnt <= w_nextRptCnt;
        end
    end

    // Next-state logic: a fresh press pulses immediately, a held press with
    // repeat enabled pulses after RPT_DELAY and then every RPT_PERIOD cycles.
    // Release is checked first so it always wins over a terminal count.
    always_comb begin
        w_nextState  = r_state;
        w_nextRptCnt = r_rptCnt;
        w_incNext    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_dbLevel) begin
                    w_incNext    = 1'b1;
                    w_nextRptCnt = '0;
                    w_nextState  = HOLD;
                end
            end
            HOLD: begin
                if (!r_dbLevel) begin
                    w_nextRptCnt = '0;
                    w_nextState  = IDLE;
                end else if (!r_rptSync) begin
                    w_nextRptCnt = '0;
                end else if (r_rptCnt == DELAY_LAST) begin
                    w_incNext    = 1'b1;
                    w_nextRptCnt = '0;
                    w_nextState  = REPEAT;
                end else begin
                    w_nextRptCnt = r_rptCnt + 1'b1;
                end
            end
            REPEAT: begin
                if (!r_dbLevel) begin
                    w_nextRptCnt = '0;
                    w_nextState  = IDLE;
                end else if (!r_rptSync) begin
                    w_nextRptCnt = '0;
                    w_nextState  = HOLD;
                end else if (r_rptCnt == PERIOD_LAST) begin
                    w_incNext    = 1'b1;
                    w_nextRptCnt = '0;
                end else begin
                    w_nextRptCnt = r_rptCnt + 1'b1;
                end
            end
            default: begin
                w_nextRptCnt = '0;
                w_nextState  = IDLE;
            end
        endcase
    end

    // Registered outputs: the pulse and a retimed copy of the debounced level
    // leave on the same edge so pressed and the first inc rise together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inc     <= 1'b0;
            r_pressed <= 1'b0;
        end else begin
            r_inc     <= w_incNext;
            r_pressed <= r_dbLevel;
        end
    end

    assign inc     = r_inc;
    assign pressed = r_pressed;

endmodule

// File: tb/tb_inc_pulse_gen.sv
// Testbench for inc_pulse_gen: directed press/bounce/repeat/reset scenarios
// followed by randomized button activity, all checked cycle by cycle against
// a behavioural model of the button timing rules.
module tb_inc_pulse_gen;

    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RP = 3;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic btn_in = 1'b0;
    logic rpt_en = 1'b0;
    logic inc;
    logic pressed;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: input sample history, debounced level with its
    // run length of disagreeing samples, and a countdown to the next pulse.
    logic mB1, mB2, mR1, mR2;
    logic mLevel;
    int   mRun;
    logic mHeld;
    int   mDue;

    int edgeIdx = 0;
    int incLog[$];

    inc_pulse_gen #(
        .DB_CYCLES (DB),
        .RPT_DELAY (RD),
        .RPT_PERIOD(RP),
        .CW        (16)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_in (btn_in),
        .rpt_en (rpt_en),
        .inc    (inc),
        .pressed(pressed)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mB1    = 1'b0;
        mB2    = 1'b0;
        mR1    = 1'b0;
        mR2    = 1'b0;
        mLevel = 1'b0;
        mRun   = 0;
        mHeld  = 1'b0;
        mDue   = 0;
    endtask

    // Drives one cycle of inputs, advances the model across the rising edge
    // and compares both outputs just after the edge.
    task automatic applyStimulus(input logic btn, input logic rpt);
        logic expInc;
        logic expPressed;
        logic bs;
        logic rs;
        btn_in = btn;
        rpt_en = rpt;
        @(posedge clk);
        expInc     = 1'b0;
        expPressed = 1'b0;
        if (!rst_n) begin
            modelReset();
        end else begin
            bs         = mB2;
            rs         = mR2;
            expPressed = mLevel;
            if (!mHeld) begin
                if (mLevel) begin
                    expInc = 1'b1;
                    mHeld  = 1'b1;
                    mDue   = RD;
                end
            end else if (!mLevel) begin
                mHeld = 1'b0;
            end else if (!rs) begin
                mDue = RD;
            end else begin
                mDue--;
                if (mDue == 0) begin
                    expInc = 1'b1;
                    mDue   = RP;
                end
            end
            if (bs != mLevel) begin
                mRun++;
                if (mRun == DB) begin
                    mLevel = bs;
                    mRun   = 0;
                end
            end else begin
                mRun = 0;
            end
            mB2 = mB1;
            mB1 = btn;
            mR2 = mR1;
            mR1 = rpt;
        end
        #1;
        checkOutput("inc", {31'd0, inc}, {31'd0, expInc});
        checkOutput("pressed", {31'd0, pressed}, {31'd0, expPressed});
        if (inc === 1'b1) incLog.push_back(edgeIdx);
        edgeIdx++;
    endtask

    // Asserts reset between clock edges and checks the outputs drop at once.
    task automatic assertResetMidCycle();
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_inc", {31'd0, inc}, 32'd0);
        checkOutput("rst_async_pressed", {31'd0, pressed}, 32'd0);
    endtask

    task automatic releaseReset();
        #3;
        rst_n = 1'b1;
    endtask

    task automatic startLog();
        incLog.delete();
        edgeIdx = 0;
    endtask

    task automatic checkLog(input string tag, input int expEdges[$]);
        checkOutput({tag, "_count"}, incLog.size(), expEdges.size());
        foreach (expEdges[i]) begin
            checkOutput($sformatf("%s_edge%0d", tag, i),
                        (i < incLog.size()) ? incLog[i] : -1, expEdges[i]);
        end
    endtask

    initial begin
        int lastLow;
        int expEdges[$];
        logic curBtn;
        logic curRpt;

        modelReset();
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_inc", {31'd0, inc}, 32'd0);
        checkOutput("reset_pressed", {31'd0, pressed}, 32'd0);
        repeat (3) applyStimulus(1'b1, 1'b0);
        releaseReset();
        repeat (8) applyStimulus(1'b0, 1'b0);

        // Clean press with no repeat: one pulse on edge 2+DB, none on release.
        $display("[TB] clean press");
        startLog();
        repeat (30) applyStimulus(1'b1, 1'b0);
        expEdges = '{6};
        checkLog("clean_press", expEdges);
        startLog();
        repeat (12) applyStimulus(1'b0, 1'b0);
        checkOutput("clean_release_no_inc", incLog.size(), 0);

        // Bouncing input whose high runs are shorter than the debounce window.
        $display("[TB] bounce");
        startLog();
        repeat (5) begin
            repeat (3) applyStimulus(1'b1, 1'b0);
            applyStimulus(1'b0, 1'b0);
        end
        lastLow = edgeIdx - 1;
        checkOutput("bounce_no_inc", incLog.size(), 0);
        repeat (20) applyStimulus(1'b1, 1'b0);
        expEdges = '{lastLow + 1 + 2 + DB};
        checkLog("bounce_settle", expEdges);
        repeat (12) applyStimulus(1'b0, 1'b0);

        // Auto-repeat, then repeat disabled while still held.
        $display("[TB] auto-repeat");
        startLog();
        repeat (24) applyStimulus(1'b1, 1'b1);
        repeat (17) applyStimulus(1'b1, 1'b0);
        expEdges = '{6, 14, 17, 20, 23};
        checkLog("auto_repeat", expEdges);
        repeat (12) applyStimulus(1'b0, 1'b0);

        // Release lands exactly on a repeat terminal count (edge 23).
        $display("[TB] release on terminal count");
        startLog();
        repeat (17) applyStimulus(1'b1, 1'b1);
        repeat (12) applyStimulus(1'b0, 1'b1);
        expEdges = '{6, 14, 17, 20};
        checkLog("release_tc", expEdges);
        startLog();
        repeat (10) applyStimulus(1'b1, 1'b0);
        expEdges = '{6};
        checkLog("repress", expEdges);
        repeat (12) applyStimulus(1'b0, 1'b0);

        // Reset while holding, then a fresh press after reset release.
        $display("[TB] reset in hold");
        repeat (10) applyStimulus(1'b1, 1'b1);
        assertResetMidCycle();
        repeat (3) applyStimulus(1'b1, 1'b1);
        releaseReset();
        startLog();
        repeat (18) applyStimulus(1'b1, 1'b1);
        expEdges = '{6, 14, 17};
        checkLog("reset_hold", expEdges);
        repeat (12) applyStimulus(1'b0, 1'b0);

        // Randomized activity: bounce bursts, long holds, idle gaps, repeat
        // toggling and occasional asynchronous resets.
        $display("[TB] random");
        curBtn = 1'b0;
        curRpt = 1'b0;
        repeat (160) begin
            if ($urandom_range(0, 3) == 0) curRpt = ~curRpt;
            case ($urandom_range(0, 3))
                0: repeat ($urandom_range(1, 10)) applyStimulus(1'($urandom_range(0, 1)), curRpt);
                1: begin
                    curBtn = 1'b1;
                    repeat ($urandom_range(5, 40)) applyStimulus(curBtn, curRpt);
                end
                2: begin
                    curBtn = 1'b0;
                    repeat ($urandom_range(5, 20)) applyStimulus(curBtn, curRpt);
                end
                default: repeat ($urandom_range(1, 8)) applyStimulus(curBtn, curRpt);
            endcase
            if ($urandom_range(0, 29) == 0) begin
                assertResetMidCycle();
                repeat (2) applyStimulus(curBtn, curRpt);
                releaseReset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
